// File: rtl/cv32e40p_instr_packer.sv
// Packs a mixed RVC/32-bit instruction stream into word-aligned 32-bit memory words.
// Optional build macro CV32E40P_PACKER_STATS_EN adds accepted-instruction and pad counters.
module cv32e40p_instr_packer #(
  parameter logic [15:0] PAD_HALF = 16'h0001,
  parameter logic [31:0] RST_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] start_addr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic        flush_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_o,
  output logic [31:0] word_addr_o,
`ifdef CV32E40P_PACKER_STATS_EN
  output logic [31:0] instr_cnt_o,
  output logic [15:0] pad_cnt_o,
`endif
  output logic        busy_o
);

  localparam int unsigned WordW = 32;
  localparam int unsigned HalfW = 16;

  typedef enum logic {
    ALIGNED = 1'b0,
    HOLD_LO = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [HalfW-1:0]   r_lo_q, r_lo_d;
  logic [WordW-1:0]   waddr_q, waddr_d;
  logic               word_valid_q, word_valid_d;
  logic [WordW-1:0]   word_q, word_d;
  logic [WordW-1:0]   word_addr_q, word_addr_d;

  logic               slot_free_c;
  logic               accept_c;
  logic               is_32b_c;
  logic               emit_c;
  logic [WordW-1:0]   emit_word_c;
  logic               unused_addr_bit0_c;

  assign slot_free_c        = !word_valid_q || word_ready_i;
  assign instr_ready_o      = slot_free_c && !start_i && !flush_i;
  assign accept_c           = instr_valid_i && instr_ready_o;
  assign is_32b_c           = (instr_i[1:0] == 2'b11);
  assign unused_addr_bit0_c = start_addr_i[0];

  // State register and output word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ALIGNED;
      r_lo_q       <= '0;
      waddr_q      <= RST_ADDR;
      word_valid_q <= 1'b0;
      word_q       <= '0;
      word_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      r_lo_q       <= r_lo_d;
      waddr_q      <= waddr_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
      word_addr_q  <= word_addr_d;
    end
  end

  // Next-state: start beats flush beats instruction accept
  always_comb begin
    state_d      = state_q;
    r_lo_d       = r_lo_q;
    waddr_d      = waddr_q;
    word_valid_d = word_valid_q;
    word_d       = word_q;
    word_addr_d  = word_addr_q;
    emit_c       = 1'b0;
    emit_word_c  = '0;

    if (word_valid_q && word_ready_i) begin
      word_valid_d = 1'b0;
    end

    if (start_i) begin
      waddr_d = {start_addr_i[31:2], 2'b00};
      if (start_addr_i[1]) begin
        state_d = HOLD_LO;
        r_lo_d  = PAD_HALF;
      end else begin
        state_d = ALIGNED;
      end
    end else if (flush_i) begin
      if ((state_q == HOLD_LO) && slot_free_c) begin
        emit_c      = 1'b1;
        emit_word_c = {PAD_HALF, r_lo_q};
        state_d     = ALIGNED;
      end
    end else if (accept_c) begin
      case (state_q)
        ALIGNED: begin
          if (is_32b_c) begin
            emit_c      = 1'b1;
            emit_word_c = instr_i;
          end else begin
            r_lo_d  = instr_i[15:0];
            state_d = HOLD_LO;
          end
        end
        HOLD_LO: begin
          emit_c      = 1'b1;
          emit_word_c = {instr_i[15:0], r_lo_q};
          if (is_32b_c) begin
            r_lo_d = instr_i[31:16];
          end else begin
            state_d = ALIGNED;
          end
        end
        default: begin
          state_d = ALIGNED;
        end
      endcase
    end

    if (emit_c) begin
      word_valid_d = 1'b1;
      word_d       = emit_word_c;
      word_addr_d  = waddr_q;
      waddr_d      = waddr_q + WordW'(4);
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;
  assign word_addr_o  = word_addr_q;
  assign busy_o       = word_valid_q || (state_q == HOLD_LO);

`ifdef CV32E40P_PACKER_STATS_EN
  logic [31:0] instr_cnt_q;
  logic [15:0] pad_cnt_q;
  logic        pad_evt_c;

  // A pad halfword is either preloaded by a misaligned start or emitted by flush
  assign pad_evt_c = (start_i && start_addr_i[1]) ||
                     (!start_i && flush_i && (state_q == HOLD_LO) && slot_free_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
      pad_cnt_q   <= '0;
    end else begin
      if (accept_c) begin
        instr_cnt_q <= instr_cnt_q + 32'(1);
      end
      if (pad_evt_c) begin
        pad_cnt_q <= pad_cnt_q + 16'(1);
      end
    end
  end

  assign instr_cnt_o = instr_cnt_q;
  assign pad_cnt_o   = pad_cnt_q;
`endif

endmodule
